pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready pipeline stage register, optional skid entry under PIPE_SKID_EN
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Main entry M: always the beat presented downstream.
    logic              m_valid;
    logic              m_valid_nxt;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] m_data_nxt;
    logic [CTRL_W-1:0] m_ctrl;
    logic [CTRL_W-1:0] m_ctrl_nxt;
    logic [1:0]        occupancy_nxt;

    logic              accept;
    logic              drain;

    assign accept = in_valid & in_ready;
    assign drain  = m_valid & out_ready;

`ifdef PIPE_SKID_EN
    // Skid entry S: catches the one beat accepted while M is stalled, so
    // in_ready can come straight from a flop instead of from out_ready.
    logic              s_valid;
    logic              s_valid_nxt;
    logic [DATA_W-1:0] s_data;
    logic [DATA_W-1:0] s_data_nxt;
    logic [CTRL_W-1:0] s_ctrl;
    logic [CTRL_W-1:0] s_ctrl_nxt;

    assign in_ready = ~s_valid;

    // Next-state for both entries; S refills M before any new input does.
    always_comb begin
        m_valid_nxt = m_valid;
        m_data_nxt  = m_data;
        m_ctrl_nxt  = m_ctrl;
        s_valid_nxt = s_valid;
        s_data_nxt  = s_data;
        s_ctrl_nxt  = s_ctrl;
        if (flush) begin
            // Data payloads are left untouched so out_data does not toggle.
            m_valid_nxt = 1'b0;
            s_valid_nxt = 1'b0;
        end else if (!m_valid || drain) begin
            if (s_valid) begin
                // in_ready is low while S is valid, so no input competes here.
                m_valid_nxt = 1'b1;
                m_data_nxt  = s_data;
                m_ctrl_nxt  = s_ctrl;
                s_valid_nxt = 1'b0;
            end else if (accept) begin
                m_valid_nxt = 1'b1;
                m_data_nxt  = in_data;
                m_ctrl_nxt  = in_ctrl;
            end else begin
                m_valid_nxt = 1'b0;
            end
        end else if (accept) begin
            s_valid_nxt = 1'b1;
            s_data_nxt  = in_data;
            s_ctrl_nxt  = in_ctrl;
        end
        occupancy_nxt = {1'b0, m_valid_nxt} + {1'b0, s_valid_nxt};
    end

    // Skid entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
        end else begin
            s_valid <= s_valid_nxt;
            s_data  <= s_data_nxt;
            s_ctrl  <= s_ctrl_nxt;
        end
    end
`else
    // Single entry: ready when empty or when the held beat leaves this cycle.
    assign in_ready = ~m_valid | out_ready;

    // Next-state for the single entry.
    always_comb begin
        m_valid_nxt = m_valid;
        m_data_nxt  = m_data;
        m_ctrl_nxt  = m_ctrl;
        if (flush) begin
            m_valid_nxt = 1'b0;
        end else if (!m_valid || drain) begin
            if (accept) begin
                m_valid_nxt = 1'b1;
                m_data_nxt  = in_data;
                m_ctrl_nxt  = in_ctrl;
            end else begin
                m_valid_nxt = 1'b0;
            end
        end
        occupancy_nxt = {1'b0, m_valid_nxt};
    end
`endif

    // Main entry and registered occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_ctrl    <= '0;
            occupancy <= 2'd0;
        end else begin
            m_valid   <= m_valid_nxt;
            m_data    <= m_data_nxt;
            m_ctrl    <= m_ctrl_nxt;
            occupancy <= occupancy_nxt;
        end
    end

    // Bubbles carry a zero control bundle so no stale write-enable leaks downstream.
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : '0;

endmodule
